// File: rtl/ctrl_pkg.sv
// Shared control-word types for the I2S transmit path, plus frame-length helpers.
package ctrl_pkg;

  typedef enum logic {
    f16bits = 1'b0,
    f32bits = 1'b1
  } frame_size_t;

  typedef struct packed {
    logic        mute;
    frame_size_t frame_size;
  } OP_t;

  localparam int FRAME_LEN16 = 16;
  localparam int FRAME_LEN32 = 32;

  function automatic logic [5:0] frame_len(input OP_t op);
    return (op.frame_size == f16bits) ? 6'(FRAME_LEN16) : 6'(FRAME_LEN32);
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage with read/write pointers, occupancy count and
// status flags derived from the registered occupancy.
module sync_fifo_core #(
  parameter int WIDTH  = 32,
  parameter int ADDR   = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic             sclk,
  input  logic             rst_,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             wr_ok,
  output logic             rd_ok,
  output logic [ADDR:0]    level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int DEPTH = 1 << ADDR;
  localparam logic [ADDR:0] FULL_LVL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AF_L     = (ADDR+1)'(AF_LVL);
  localparam logic [ADDR:0] AE_L     = (ADDR+1)'(AE_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]    level_q, level_d;

  assign level        = level_q;
  assign full         = (level_q == FULL_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);
  assign rdata        = mem_q[rd_ptr_q];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    wr_ok    = wr_req && !full;
    rd_ok    = rd_req && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sclk) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; only valid entries are ever read.
  always_ff @(posedge sclk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tx_serial_fifo.sv
// Transmit sample buffer: FIFO of parallel words serialised MSB-first on bit_en,
// with underrun, mute, frame-abort handling and sticky error flags.
module tx_serial_fifo
  import ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR   = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic             sclk,
  input  logic             rst_,
  input  OP_t              OP,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             bit_en,
  input  logic             frame_start,
  input  logic             clr_err,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    level,
  output logic             ovf,
  output logic             udf
);

  logic             load;
  logic [WIDTH-1:0] head;
  logic             wr_ok, rd_ok;
  logic [31:0]      load_word;

  logic [31:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dout_q, dout_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  assign load = frame_start && bit_en;
  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign udf  = udf_q;

  sync_fifo_core #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR),
    .AF_LVL(AF_LVL),
    .AE_LVL(AE_LVL)
  ) u_core (
    .sclk        (sclk),
    .rst_        (rst_),
    .wr_req      (wr_en),
    .rd_req      (load),
    .wdata       (din),
    .rdata       (head),
    .wr_ok       (wr_ok),
    .rd_ok       (rd_ok),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always_comb begin
    // Left-align the outgoing word in a 32-bit shifter; an underrun sends zeros.
    load_word = '0;
    if (rd_ok) begin
      if (OP.frame_size == f16bits) load_word = {head[15:0], 16'h0000};
      else                          load_word = 32'(head) << (32 - WIDTH);
    end

    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    if (load) begin
      dout_d  = load_word[31];
      shift_d = load_word << 1;
      cnt_d   = 5'(frame_len(OP) - 6'd1);
    end else if (bit_en) begin
      if (cnt_q != '0) begin
        dout_d  = shift_q[31];
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - 1'b1;
      end else begin
        dout_d = 1'b0;
      end
    end
    if (OP.mute) dout_d = 1'b0;

    // A clear and a fresh error in the same cycle leave the flag set.
    ovf_d = clr_err ? 1'b0 : ovf_q;
    udf_d = clr_err ? 1'b0 : udf_q;
    if (wr_en && !wr_ok) ovf_d = 1'b1;
    if (load && !rd_ok)  udf_d = 1'b1;
  end

  always_ff @(posedge sclk) begin
    if (!rst_) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

endmodule
